// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: operand routing
// encodings and default geometry.
package regfile_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
   localparam int DEF_NUM_DLY  = 2;

   typedef enum logic [1:0] {
      MODE_NORMAL = 2'b00,
      MODE_ONE_OP = 2'b01,
      MODE_SWAP   = 2'b10,
      MODE_IMM    = 2'b11
   } op_mode_e;

endpackage

// File: rtl/param_reg_file_if.sv
// Decode/write-back side bus of the register file. The pipeline drives the
// master modport; the register file takes the slave modport.
interface param_reg_file_if
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int NUM_DLY = DEF_NUM_DLY
) ();

   logic                        stall;
   logic                        flush;
   logic                        rd_req;
   logic [ADDR_W-1:0]           src_a;
   logic [ADDR_W-1:0]           src_b;
   logic [1:0]                  op_mode;
   logic [DATA_W-1:0]           imm;
   logic                        wr0_en;
   logic [ADDR_W-1:0]           wr0_addr;
   logic [DATA_W-1:0]           wr0_data;
   logic                        wr1_en;
   logic [ADDR_W-1:0]           wr1_addr;
   logic [DATA_W-1:0]           wr1_data;
   logic                        rd_valid;
   logic [DATA_W-1:0]           rd_a;
   logic [DATA_W-1:0]           rd_b;
   logic [NUM_DLY-1:0]          dly_valid;
   logic [NUM_DLY*DATA_W-1:0]   dly_a;
   logic [NUM_DLY*DATA_W-1:0]   dly_b;

   modport master (
      output stall, flush, rd_req, src_a, src_b, op_mode, imm,
             wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
      input  rd_valid, rd_a, rd_b, dly_valid, dly_a, dly_b
   );

   modport slave (
      input  stall, flush, rd_req, src_a, src_b, op_mode, imm,
             wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
      output rd_valid, rd_a, rd_b, dly_valid, dly_a, dly_b
   );

endinterface

// File: rtl/operand_delay_line.sv
// Shift register of DEPTH stages for packed {valid, A, B} operand words,
// with hold on stall and clear on flush (flush has priority).
module operand_delay_line #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [DEPTH*WIDTH-1:0]   dout
);

   logic [WIDTH-1:0] stg_p1 [DEPTH];

   // stage boundary: stg_p1[k] is delay stage k+1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) stg_p1[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k < DEPTH; k++) stg_p1[k] <= '0;
      end else if (!stall) begin
         stg_p1[0] <= din;
         for (int k = 1; k < DEPTH; k++) stg_p1[k] <= stg_p1[k-1];
      end
   end

   always_comb begin
      dout = '0;
      for (int k = 0; k < DEPTH; k++) dout[k*WIDTH +: WIDTH] = stg_p1[k];
   end

endmodule

// File: rtl/param_reg_file.sv
// Two-write-port register file with write-to-read bypass, operand routing
// modes, optional hard-wired zero register and an aligned operand delay line.
module param_reg_file
   import regfile_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int ADDR_W     = $clog2(NUM_REGS),
   parameter int NUM_DLY    = DEF_NUM_DLY,
   parameter int ZERO_REG   = 0,
   parameter int INIT_INDEX = 1
) (
   input logic              clk,
   input logic              reset_n,
   param_reg_file_if.slave  bus
);

   localparam int LW = 2*DATA_W + 1;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] eff_a, eff_b, a_nxt, b_nxt;
   logic              vld_p0;
   logic [DATA_W-1:0] a_p0, b_p0;
   logic [NUM_DLY*LW-1:0]     dly_word;
   logic [NUM_DLY-1:0]        dly_v;
   logic [NUM_DLY*DATA_W-1:0] dly_a_w, dly_b_w;

   // Port 1 is checked first so it wins a same-address collision, matching
   // the write ordering in the register array below.
   function automatic logic [DATA_W-1:0] bypass(
      input logic [ADDR_W-1:0] x,
      input logic [DATA_W-1:0] rx,
      input logic              w0_en,
      input logic [ADDR_W-1:0] w0_addr,
      input logic [DATA_W-1:0] w0_data,
      input logic              w1_en,
      input logic [ADDR_W-1:0] w1_addr,
      input logic [DATA_W-1:0] w1_data
   );
      if (ZERO_REG != 0 && x == '0) return '0;
      if (w1_en && w1_addr == x)    return w1_data;
      if (w0_en && w0_addr == x)    return w0_data;
      return rx;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
      end else begin
         if (bus.wr0_en && !(ZERO_REG != 0 && bus.wr0_addr == '0))
            regs[bus.wr0_addr] <= bus.wr0_data;
         if (bus.wr1_en && !(ZERO_REG != 0 && bus.wr1_addr == '0))
            regs[bus.wr1_addr] <= bus.wr1_data;
      end
   end

   always_comb begin
      eff_a = bypass(bus.src_a, regs[bus.src_a], bus.wr0_en, bus.wr0_addr,
                     bus.wr0_data, bus.wr1_en, bus.wr1_addr, bus.wr1_data);
      eff_b = bypass(bus.src_b, regs[bus.src_b], bus.wr0_en, bus.wr0_addr,
                     bus.wr0_data, bus.wr1_en, bus.wr1_addr, bus.wr1_data);
      a_nxt = eff_a;
      b_nxt = eff_b;
      case (op_mode_e'(bus.op_mode))
         MODE_ONE_OP: b_nxt = eff_a;
         MODE_SWAP: begin
            a_nxt = eff_b;
            b_nxt = eff_a;
         end
         MODE_IMM:    b_nxt = bus.imm;
         default:     ;
      endcase
   end

   // stage boundary: read stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p0 <= 1'b0;
         a_p0   <= '0;
         b_p0   <= '0;
      end else if (bus.flush) begin
         vld_p0 <= 1'b0;
         a_p0   <= '0;
         b_p0   <= '0;
      end else if (!bus.stall) begin
         vld_p0 <= bus.rd_req;
         a_p0   <= a_nxt;
         b_p0   <= b_nxt;
      end
   end

   operand_delay_line #(
      .WIDTH (LW),
      .DEPTH (NUM_DLY)
   ) u_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .stall   (bus.stall),
      .flush   (bus.flush),
      .din     ({vld_p0, a_p0, b_p0}),
      .dout    (dly_word)
   );

   always_comb begin
      dly_v   = '0;
      dly_a_w = '0;
      dly_b_w = '0;
      for (int k = 0; k < NUM_DLY; k++) begin
         dly_v[k]                    = dly_word[k*LW + 2*DATA_W];
         dly_a_w[k*DATA_W +: DATA_W] = dly_word[k*LW + DATA_W +: DATA_W];
         dly_b_w[k*DATA_W +: DATA_W] = dly_word[k*LW +: DATA_W];
      end
   end

   assign bus.rd_valid  = vld_p0;
   assign bus.rd_a      = a_p0;
   assign bus.rd_b      = b_p0;
   assign bus.dly_valid = dly_v;
   assign bus.dly_a     = dly_a_w;
   assign bus.dly_b     = dly_b_w;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: one instance with ZERO_REG=0 and one with
// ZERO_REG=1 share the same stimulus.
module tb_param_reg_file;

   logic clk;
   logic reset_n;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;

   param_reg_file_if #(.DATA_W(16), .ADDR_W(3), .NUM_DLY(2)) bif ();
   param_reg_file_if #(.DATA_W(16), .ADDR_W(3), .NUM_DLY(2)) zif ();

   param_reg_file #(
      .DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .NUM_DLY(2), .ZERO_REG(0), .INIT_INDEX(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bif.slave)
   );

   param_reg_file #(
      .DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .NUM_DLY(2), .ZERO_REG(1), .INIT_INDEX(1)
   ) dut_z (
      .clk(clk), .reset_n(reset_n), .bus(zif.slave)
   );

   assign zif.stall    = bif.stall;
   assign zif.flush    = bif.flush;
   assign zif.rd_req   = bif.rd_req;
   assign zif.src_a    = bif.src_a;
   assign zif.src_b    = bif.src_b;
   assign zif.op_mode  = bif.op_mode;
   assign zif.imm      = bif.imm;
   assign zif.wr0_en   = bif.wr0_en;
   assign zif.wr0_addr = bif.wr0_addr;
   assign zif.wr0_data = bif.wr0_data;
   assign zif.wr1_en   = bif.wr1_en;
   assign zif.wr1_addr = bif.wr1_addr;
   assign zif.wr1_data = bif.wr1_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic req, input logic [2:0] a, input logic [2:0] b,
                     input logic [1:0] mode);
      bif.rd_req  = req;
      bif.src_a   = a;
      bif.src_b   = b;
      bif.op_mode = mode;
   endtask

   task automatic wr(input logic e0, input logic [2:0] a0, input logic [15:0] d0,
                     input logic e1, input logic [2:0] a1, input logic [15:0] d1);
      bif.wr0_en = e0; bif.wr0_addr = a0; bif.wr0_data = d0;
      bif.wr1_en = e1; bif.wr1_addr = a1; bif.wr1_data = d1;
   endtask

   initial begin
      reset_n   = 1'b0;
      bif.stall = 1'b0;
      bif.flush = 1'b0;
      bif.imm   = '0;
      rd(1'b0, 3'd0, 3'd0, 2'b00);
      wr(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

      tick();
      tick();
      chk("reset_rd_valid",  64'(bif.rd_valid),  64'h0);
      chk("reset_rd_a",      64'(bif.rd_a),      64'h0);
      chk("reset_dly_valid", 64'(bif.dly_valid), 64'h0);
      chk("reset_dly_a",     64'(bif.dly_a),     64'h0);
      #3 reset_n = 1'b1;

      // basic read and delay alignment
      rd(1'b1, 3'd3, 3'd5, 2'b00);
      tick();
      chk("read_rd_a",     64'(bif.rd_a),     64'h3);
      chk("read_rd_b",     64'(bif.rd_b),     64'h5);
      chk("read_rd_valid", 64'(bif.rd_valid), 64'h1);
      rd(1'b0, 3'd0, 3'd0, 2'b00);
      tick();
      chk("dly1_a",        64'(bif.dly_a[15:0]), 64'h3);
      chk("dly1_b",        64'(bif.dly_b[15:0]), 64'h5);
      chk("dly_valid_s1",  64'(bif.dly_valid),   64'h1);
      chk("rd_valid_idle", 64'(bif.rd_valid),    64'h0);
      tick();
      chk("dly2_a",        64'(bif.dly_a[31:16]), 64'h3);
      chk("dly_valid_s2",  64'(bif.dly_valid),    64'h2);

      // bypass
      wr(1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 16'h0);
      rd(1'b1, 3'd2, 3'd0, 2'b00);
      tick();
      chk("bypass_wr0", 64'(bif.rd_a), 64'h1234);
      wr(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'hBEEF);
      tick();
      chk("bypass_wr1_wins", 64'(bif.rd_a), 64'hBEEF);
      wr(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      tick();
      chk("reg_wr1_wins", 64'(bif.rd_a), 64'hBEEF);
      chk("reg_r0",       64'(bif.rd_b), 64'h0);

      // operand routing modes
      wr(1'b1, 3'd1, 16'h00AA, 1'b1, 3'd4, 16'h0055);
      rd(1'b0, 3'd0, 3'd0, 2'b00);
      tick();
      wr(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      rd(1'b1, 3'd1, 3'd4, 2'b00);
      tick();
      chk("mode00_a", 64'(bif.rd_a), 64'h00AA);
      chk("mode00_b", 64'(bif.rd_b), 64'h0055);
      rd(1'b1, 3'd1, 3'd4, 2'b01);
      tick();
      chk("mode01_a", 64'(bif.rd_a), 64'h00AA);
      chk("mode01_b", 64'(bif.rd_b), 64'h00AA);
      rd(1'b1, 3'd1, 3'd4, 2'b10);
      tick();
      chk("mode10_a", 64'(bif.rd_a), 64'h0055);
      chk("mode10_b", 64'(bif.rd_b), 64'h00AA);
      bif.imm = 16'h7FFF;
      rd(1'b1, 3'd1, 3'd4, 2'b11);
      tick();
      chk("mode11_a", 64'(bif.rd_a), 64'h00AA);
      chk("mode11_b", 64'(bif.rd_b), 64'h7FFF);

      // stall and flush
      rd(1'b1, 3'd1, 3'd4, 2'b00);
      tick();
      rd(1'b1, 3'd3, 3'd5, 2'b00);
      tick();
      rd(1'b1, 3'd4, 3'd1, 2'b00);
      tick();
      bif.stall = 1'b1;
      rd(1'b1, 3'd6, 3'd7, 2'b00);
      wr(1'b1, 3'd1, 16'h0BAD, 1'b1, 3'd4, 16'h4444);
      tick();
      wr(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      chk("stall1_rd_a",      64'(bif.rd_a),      64'h0055);
      chk("stall1_rd_b",      64'(bif.rd_b),      64'h00AA);
      chk("stall1_dly_a",     64'(bif.dly_a),     64'h00AA_0003);
      chk("stall1_dly_b",     64'(bif.dly_b),     64'h0055_0005);
      chk("stall1_dly_valid", 64'(bif.dly_valid), 64'h3);
      tick();
      chk("stall2_rd_a",     64'(bif.rd_a),     64'h0055);
      chk("stall2_rd_valid", 64'(bif.rd_valid), 64'h1);
      chk("stall2_dly_a",    64'(bif.dly_a),    64'h00AA_0003);
      bif.flush = 1'b1;
      tick();
      chk("flush_rd_valid",  64'(bif.rd_valid),  64'h0);
      chk("flush_rd_a",      64'(bif.rd_a),      64'h0);
      chk("flush_rd_b",      64'(bif.rd_b),      64'h0);
      chk("flush_dly_valid", 64'(bif.dly_valid), 64'h0);
      chk("flush_dly_a",     64'(bif.dly_a),     64'h0);
      chk("flush_dly_b",     64'(bif.dly_b),     64'h0);
      bif.flush = 1'b0;
      bif.stall = 1'b0;
      rd(1'b1, 3'd1, 3'd4, 2'b00);
      tick();
      chk("stall_write_r1", 64'(bif.rd_a),      64'h0BAD);
      chk("stall_write_r4", 64'(bif.rd_b),      64'h4444);
      chk("post_flush_dlyv", 64'(bif.dly_valid), 64'h0);

      // hard-wired zero register
      wr(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0);
      rd(1'b1, 3'd0, 3'd0, 2'b00);
      tick();
      chk("zero_bypass_a",  64'(zif.rd_a),     64'h0);
      chk("zero_bypass_b",  64'(zif.rd_b),     64'h0);
      chk("zero_valid",     64'(zif.rd_valid), 64'h1);
      chk("nozero_bypass",  64'(bif.rd_a),     64'hFFFF);
      wr(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      tick();
      chk("zero_later",     64'(zif.rd_a),     64'h0);
      chk("nozero_later",   64'(bif.rd_a),     64'hFFFF);

      // asynchronous reset between edges
      wr(1'b1, 3'd3, 16'h9999, 1'b0, 3'd0, 16'h0);
      rd(1'b1, 3'd3, 3'd1, 2'b00);
      #3 reset_n = 1'b0;
      #1;
      chk("areset_rd_valid",  64'(bif.rd_valid),  64'h0);
      chk("areset_rd_a",      64'(bif.rd_a),      64'h0);
      chk("areset_rd_b",      64'(bif.rd_b),      64'h0);
      chk("areset_dly_valid", 64'(bif.dly_valid), 64'h0);
      chk("areset_dly_a",     64'(bif.dly_a),     64'h0);
      chk("areset_dly_b",     64'(bif.dly_b),     64'h0);
      wr(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      #1 reset_n = 1'b1;
      tick();
      chk("areset_r3_index", 64'(bif.rd_a), 64'h3);
      chk("areset_r1_index", 64'(bif.rd_b), 64'h1);
      chk("areset_z_r3",     64'(zif.rd_a), 64'h3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
Parametrised successor to the processor's 8x16 register file. It provides two write ports, write-to-read bypass, four operand-routing modes, an optional hard-wired zero register, and a configurable operand delay line with valid, stall and flush. It sits between decode (read) and write-back (write) and feeds the execute and memory stages with aligned operand copies. All state is updated on the rising edge only.

Parameters:
DATA_W, 16, register and operand width in bits
NUM_REGS, 8, number of architectural registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register address width
NUM_DLY, 2, number of delayed operand stages after the read stage (>=1)
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
INIT_INDEX, 1, 1 = on reset register i holds i; 0 = all registers hold 0

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold the read stage and the delay line
flush  in  1  clear the read stage and the delay line
rd_req  in  1  a valid operand read is presented this cycle
src_a  in  ADDR_W  operand A address
src_b  in  ADDR_W  operand B address
op_mode  in  2  operand routing: 00 normal, 01 one-operand, 10 swap, 11 immediate
imm  in  DATA_W  immediate value used as B in mode 11
wr0_en  in  1  write port 0 enable (write-back)
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (secondary or swap write)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
rd_valid  out  1  read stage holds valid operands
rd_a  out  DATA_W  operand A, read stage
rd_b  out  DATA_W  operand B, read stage
dly_valid  out  NUM_DLY  valid bit per delay stage; bit k-1 = stage k
dly_a  out  NUM_DLY*DATA_W  operand A per delay stage; slice k-1 = stage k
dly_b  out  NUM_DLY*DATA_W  operand B per delay stage

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Registers: R[i]=i if INIT_INDEX=1, else 0. R[0]=0 when ZERO_REG=1.
  - All outputs (valid bits and data) go to 0.
  - Reset mid-operation discards every in-flight operand and every pending write.
- Writes, rising edge:
  - wr0_en writes R[wr0_addr] and wr1_en writes R[wr1_addr].
  - Same address on both ports: port 1 wins.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - Writes occur regardless of stall and flush.
- Bypass: effective value E(x) = wr1_data if wr1_en and wr1_addr==x; else wr0_data if wr0_en and wr0_addr==x; else R[x]. E(0)=0 when ZERO_REG=1; bypass never overrides this.
- Read stage, rising edge, when stall=0 and flush=0:
  - rd_valid <= rd_req.
  - mode 00: rd_a<=E(src_a), rd_b<=E(src_b).
  - mode 01: rd_a<=E(src_a), rd_b<=E(src_a).
  - mode 10: rd_a<=E(src_b), rd_b<=E(src_a).
  - mode 11: rd_a<=E(src_a), rd_b<=imm.
  - rd_req=0: the data fields still update; only rd_valid marks the data as meaningful.
- Latency: operands appear 1 cycle after the address; delay stage k holds them k+1 cycles after the address.
- Delay line, when stall=0 and flush=0: stage 1 <= read stage; stage k+1 <= stage k. Each stage carries valid, A and B together.
- stall=1 (flush=0): the read stage and all delay stages hold.
- flush=1: the read stage and all delay stages clear valid and data to 0 on the next edge. Flush overrides stall.
- Stalled operands are not re-bypassed: a held read stage keeps the old value even if its source register is written during the stall.
- Addresses are always in range (NUM_REGS is a power of two), so no out-of-range handling is needed.

Decomposition:
- Shared package (regfile_pkg): op_mode encodings (MODE_NORMAL, MODE_ONE_OP, MODE_SWAP, MODE_IMM) and default widths.
- One sub-module: operand_delay_line, parametrised by WIDTH (2*DATA_W+1) and DEPTH (NUM_DLY), with stall, flush and asynchronous active-low reset. Instantiated once, fed by the concatenation {valid, A, B}.

Test Plan:
- Reset, INIT_INDEX=1: rd_req, mode 00, src_a=3, src_b=5 -> next cycle rd_a=3, rd_b=5, rd_valid=1; dly_a stage1=3 one cycle later.
- Bypass: wr0 R2<=0x1234 in the same cycle as a read of src_a=2 -> rd_a=0x1234. wr1 R2<=0xBEEF in the same cycle as wr0 R2<=0x1111 -> R2 and rd_a = 0xBEEF.
- Modes with R1=0x00AA, R4=0x0055, src_a=1, src_b=4:
  - 01 -> A=B=0x00AA.
  - 10 -> A=0x0055, B=0x00AA.
  - 11 with imm=0x7FFF -> A=0x00AA, B=0x7FFF.
- Stall and flush: issue 3 reads, assert stall 2 cycles -> rd and dly outputs frozen while a write to R1 still lands. Assert flush together with stall -> all valids and data 0 next edge.
- ZERO_REG=1: write R0<=0xFFFF on wr0 and read R0 in the same cycle -> rd_a=0; a later read also returns 0.
- Asynchronous reset mid-stream: pulse reset_n low between clock edges -> all outputs 0 immediately; registers return to index values.
